// File: rtl/pulse_train_seq.sv
// pulse_train_seq: runs a train of bias/pulse/ADC shots for one decoded
// measurement command, with switch settle time, programmable inter-shot gap,
// abort and shot indexing.
//
// Optional feature macro: SEQ_WDOG_EN
//   defined     -> per-shot watchdog in WAIT_DONE; expiry behaves as an abort
//                  and sets the sticky err_timeout flag.
//   not defined -> no watchdog counter, err_timeout tied to 0.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_sw/rep/gap/wid  command fields (rep 0 treated as 1)
//   abort               terminate the running sequence
//   pulse_done          done pulse from the input-DAC engine
//   sw                  registered switch-matrix drive
//   wid_q, bias_wid     latched pulse width and width+1 (no wrap)
//   bias_start, pulse_start, ad_start   one-cycle engine strobes
//   pulse_idx           0-based index of the current shot
//   busy                high whenever not IDLE
//   seq_done, aborted   one-cycle completion / abort pulses
//   err_timeout         sticky watchdog flag
module pulse_train_seq #(
    parameter int unsigned SW_W               = 9,
    parameter logic [SW_W-1:0] SW_IDLE        = SW_W'(9'b1_0000_0000),
    parameter int unsigned REP_W              = 8,
    parameter int unsigned GAP_W              = 16,
    parameter int unsigned WID_W              = 32,
    parameter int unsigned SW_SETTLE          = 4,
    parameter int unsigned WDOG_CYC           = 2**24 - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SW_W-1:0]    cmd_sw,
    input  logic [REP_W-1:0]   cmd_rep,
    input  logic [GAP_W-1:0]   cmd_gap,
    input  logic [WID_W-1:0]   cmd_wid,
    input  logic               abort,
    input  logic               pulse_done,
    output logic [SW_W-1:0]    sw,
    output logic [WID_W-1:0]   wid_q,
    output logic [WID_W:0]     bias_wid,
    output logic               bias_start,
    output logic               pulse_start,
    output logic               ad_start,
    output logic [REP_W-1:0]   pulse_idx,
    output logic               busy,
    output logic               seq_done,
    output logic               aborted,
    output logic               err_timeout
);

    // A zero settle time still spends one cycle in SETTLE.
    localparam int unsigned SETTLE_CYC = (SW_SETTLE == 0) ? 1 : SW_SETTLE;
    localparam int unsigned SET_W      = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_BIAS,
        S_PULSE,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t             state;
    logic [SET_W-1:0]   set_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_q;
    logic [REP_W-1:0]   rep_eff;
    logic               timeout_c;

    // A zero watchdog period can never be met by any shot.
    if (WDOG_CYC == 0) begin : g_bad_wdog
        $error("pulse_train_seq: WDOG_CYC must be non-zero");
    end

`ifdef SEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_cnt;

    // Fires on the last WAIT_DONE cycle of the allowed window.
    assign timeout_c = (state == S_WAIT) && !pulse_done &&
                       (wdog_cnt == WD_W'(WDOG_CYC - 1));
`else
    assign timeout_c   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            set_cnt     <= '0;
            gap_cnt     <= '0;
            gap_q       <= '0;
            rep_eff     <= REP_W'(1);
            sw          <= SW_IDLE;
            wid_q       <= '0;
            bias_wid    <= (WID_W+1)'(1);
            bias_start  <= 1'b0;
            pulse_start <= 1'b0;
            ad_start    <= 1'b0;
            pulse_idx   <= '0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            seq_done    <= 1'b0;
            aborted     <= 1'b0;
`ifdef SEQ_WDOG_EN
            wdog_cnt    <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            bias_start  <= 1'b0;
            pulse_start <= 1'b0;
            ad_start    <= 1'b0;
            seq_done    <= 1'b0;
            aborted     <= 1'b0;

            // Abort (or watchdog expiry) outranks every state action.
            if ((state != S_IDLE) && (abort || timeout_c)) begin
                state     <= S_IDLE;
                sw        <= SW_IDLE;
                aborted   <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
`ifdef SEQ_WDOG_EN
                if (timeout_c) begin
                    err_timeout <= 1'b1;
                end
`endif
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            state     <= S_SETTLE;
                            set_cnt   <= '0;
                            sw        <= cmd_sw;
                            wid_q     <= cmd_wid;
                            bias_wid  <= {1'b0, cmd_wid} + (WID_W+1)'(1);
                            gap_q     <= cmd_gap;
                            rep_eff   <= (cmd_rep == '0) ? REP_W'(1) : cmd_rep;
                            pulse_idx <= '0;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
`ifdef SEQ_WDOG_EN
                            err_timeout <= 1'b0;
`endif
                        end
                    end

                    S_SETTLE: begin
                        if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
                            state      <= S_BIAS;
                            bias_start <= 1'b1;
                        end else begin
                            set_cnt <= set_cnt + SET_W'(1);
                        end
                    end

                    S_BIAS: begin
                        state       <= S_PULSE;
                        pulse_start <= 1'b1;
                        ad_start    <= 1'b1;
                    end

                    S_PULSE: begin
                        state <= S_WAIT;
`ifdef SEQ_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end

                    S_WAIT: begin
                        if (pulse_done) begin
                            if ((pulse_idx + REP_W'(1)) == rep_eff) begin
                                state    <= S_FINISH;
                                seq_done <= 1'b1;
                            end else begin
                                pulse_idx <= pulse_idx + REP_W'(1);
                                if (gap_q == '0) begin
                                    state      <= S_BIAS;
                                    bias_start <= 1'b1;
                                end else begin
                                    state   <= S_GAP;
                                    gap_cnt <= '0;
                                end
                            end
                        end
`ifdef SEQ_WDOG_EN
                        else begin
                            wdog_cnt <= wdog_cnt + WD_W'(1);
                        end
`endif
                    end

                    S_GAP: begin
                        if (gap_cnt == (gap_q - GAP_W'(1))) begin
                            state      <= S_BIAS;
                            bias_start <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end

                    S_FINISH: begin
                        state     <= S_IDLE;
                        sw        <= SW_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end

                    default: begin
                        state     <= S_IDLE;
                        sw        <= SW_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_seq.sv
// tb_pulse_train_seq: self-checking bench for pulse_train_seq. Expected strobe
// cycles are computed from the shot-schedule rules (settle, gap, done+1) and
// compared against the strobe times recorded by a negedge monitor.
module tb_pulse_train_seq;

    localparam int unsigned SW_W   = 9;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned GAP_W  = 16;
    localparam int unsigned WID_W  = 32;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned WDOG   = 100;
    localparam logic [SW_W-1:0] SW_IDLE_V = 9'h100;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [SW_W-1:0]    cmd_sw;
    logic [REP_W-1:0]   cmd_rep;
    logic [GAP_W-1:0]   cmd_gap;
    logic [WID_W-1:0]   cmd_wid;
    logic               abort;
    logic               pulse_done;
    logic [SW_W-1:0]    sw;
    logic [WID_W-1:0]   wid_q;
    logic [WID_W:0]     bias_wid;
    logic               bias_start;
    logic               pulse_start;
    logic               ad_start;
    logic [REP_W-1:0]   pulse_idx;
    logic               busy;
    logic               seq_done;
    logic               aborted;
    logic               err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int q_bias[$];
    int q_pulse[$];
    int q_ad[$];
    int q_idx[$];
    int q_done[$];
    int q_abrt[$];

    pulse_train_seq #(
        .SW_W      (SW_W),
        .SW_IDLE   (SW_IDLE_V),
        .REP_W     (REP_W),
        .GAP_W     (GAP_W),
        .WID_W     (WID_W),
        .SW_SETTLE (SETTLE),
        .WDOG_CYC  (WDOG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_sw      (cmd_sw),
        .cmd_rep     (cmd_rep),
        .cmd_gap     (cmd_gap),
        .cmd_wid     (cmd_wid),
        .abort       (abort),
        .pulse_done  (pulse_done),
        .sw          (sw),
        .wid_q       (wid_q),
        .bias_wid    (bias_wid),
        .bias_start  (bias_start),
        .pulse_start (pulse_start),
        .ad_start    (ad_start),
        .pulse_idx   (pulse_idx),
        .busy        (busy),
        .seq_done    (seq_done),
        .aborted     (aborted),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of every strobe; pulse_idx is captured with bias_start.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bias_start) begin
                q_bias.push_back(cyc);
                q_idx.push_back(int'(pulse_idx));
            end
            if (pulse_start) q_pulse.push_back(cyc);
            if (ad_start)    q_ad.push_back(cyc);
            if (seq_done)    q_done.push_back(cyc);
            if (aborted)     q_abrt.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_bias.delete();
        q_pulse.delete();
        q_ad.delete();
        q_idx.delete();
        q_done.delete();
        q_abrt.delete();
    endtask

    // Issue one command and play the pulse_done engine; abort_shot >= 0 asserts
    // abort together with that shot's pulse_done; poke sends a second command
    // while the first shot waits for done.
    task automatic run_cmd(input logic [SW_W-1:0] sw_v, input int rep, input int gap,
                           input logic [WID_W-1:0] wid, input int lat_min, input int lat_max,
                           input int abort_shot, input bit poke);
        int t0;
        int reps;
        int nshots;
        int p;
        int d;
        int lat;
        int budget;
        int eb[$];
        logic [WID_W:0] exp_bw;

        clear_q();
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            step();
            budget++;
        end
        chk("cmd_ready_before_cmd", cmd_ready, 1);

        t0 = cyc;
        cmd_valid = 1'b1;
        cmd_sw    = sw_v;
        cmd_rep   = REP_W'(rep);
        cmd_gap   = GAP_W'(gap);
        cmd_wid   = wid;
        step();
        cmd_valid = 1'b0;
        cmd_sw    = SW_W'($urandom);
        cmd_wid   = $urandom;
        cmd_gap   = GAP_W'($urandom);
        cmd_rep   = REP_W'($urandom);

        exp_bw = {1'b0, wid} + 33'd1;
        chk("sw_latched", sw, sw_v);
        chk("wid_q", wid_q, wid);
        chk("bias_wid", bias_wid, exp_bw);
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("err_timeout_clear", err_timeout, 0);

        reps   = (rep == 0) ? 1 : rep;
        nshots = (abort_shot >= 0) ? abort_shot + 1 : reps;
        eb.push_back(t0 + 1 + int'(SETTLE));
        d = 0;

        for (int k = 0; k < nshots; k++) begin
            budget = 0;
            while (!pulse_start && budget < 300) begin
                step();
                budget++;
            end
            chk("pulse_start_seen", pulse_start, 1);
            if (!pulse_start) return;
            p   = cyc;
            lat = int'($urandom_range(lat_max, lat_min));
            if (poke && k == 0) begin
                step();
                cmd_valid = 1'b1;
                cmd_sw    = ~sw_v;
                cmd_rep   = 8'd9;
                step();
                cmd_valid = 1'b0;
                chk("sw_hold_while_busy", sw, sw_v);
            end
            while (cyc < p + lat) step();
            pulse_done = 1'b1;
            if (k == abort_shot) abort = 1'b1;
            d = cyc;
            step();
            pulse_done = 1'b0;
            abort      = 1'b0;
            if (k + 1 < nshots) eb.push_back(d + 1 + gap);
            if (abort_shot < 0) begin
                chk("pulse_idx_after_done", pulse_idx, (k + 1 < reps) ? k + 1 : k);
            end
        end

        if (abort_shot >= 0) begin
            chk("busy_after_abort", busy, 0);
            chk("ready_after_abort", cmd_ready, 1);
            chk("sw_idle_after_abort", sw, SW_IDLE_V);
        end else begin
            chk("busy_in_finish", busy, 1);
            step();
            chk("busy_after_finish", busy, 0);
            chk("ready_after_finish", cmd_ready, 1);
            chk("sw_idle_after_finish", sw, SW_IDLE_V);
            chk("pulse_idx_hold", pulse_idx, reps - 1);
        end

        for (int i = 0; i < gap + 8; i++) step();

        chk("n_bias", q_bias.size(), nshots);
        chk("n_pulse", q_pulse.size(), nshots);
        chk("n_ad", q_ad.size(), nshots);
        for (int k = 0; k < nshots && k < q_bias.size() && k < q_pulse.size() && k < q_ad.size(); k++) begin
            chk("bias_cycle", q_bias[k], eb[k]);
            chk("pulse_cycle", q_pulse[k], eb[k] + 1);
            chk("ad_cycle", q_ad[k], eb[k] + 1);
            chk("idx_at_bias", q_idx[k], k);
        end
        if (abort_shot >= 0) begin
            chk("n_seq_done_abort", q_done.size(), 0);
            chk("n_aborted", q_abrt.size(), 1);
            if (q_abrt.size() == 1) chk("aborted_cycle", q_abrt[0], d + 1);
        end else begin
            chk("n_seq_done", q_done.size(), 1);
            chk("n_aborted_normal", q_abrt.size(), 0);
            if (q_done.size() == 1) chk("seq_done_cycle", q_done[0], d + 1);
        end
    endtask

    initial begin
        int p;
        int budget;
        logic [SW_W-1:0] rsw;
        int rrep;
        int rgap;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_sw     = '0;
        cmd_rep    = '0;
        cmd_gap    = '0;
        cmd_wid    = '0;
        abort      = 1'b0;
        pulse_done = 1'b0;
        step();
        step();
        chk("rst_sw", sw, SW_IDLE_V);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_idx", pulse_idx, 0);
        chk("rst_wid_q", wid_q, 0);
        chk("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        step();

        // Abort while idle must do nothing.
        clear_q();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("idle_abort_ignored", q_abrt.size(), 0);
        chk("idle_abort_busy", busy, 0);

        // Directed: single shot with rep 0, long done latency.
        run_cmd(9'h003, 0, 0, 32'h0000_1234, 20, 20, -1, 1'b0);
        // Directed: three-shot train with gap 10.
        run_cmd(9'h0A5, 3, 10, 32'hDEAD_BEEF, 5, 5, -1, 1'b0);
        // Directed: abort together with the second done of a four-shot run.
        run_cmd(9'h055, 4, 2, 32'h0000_0010, 2, 6, 1, 1'b0);
        // Directed: command while busy is ignored; max width has no wrap.
        run_cmd(9'h0F0, 2, 3, 32'hFFFF_FFFF, 4, 7, -1, 1'b1);

        // Randomized commands.
        for (int i = 0; i < 6; i++) begin
            rsw  = SW_W'($urandom);
            rrep = int'($urandom_range(4, 0));
            rgap = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            run_cmd(rsw, rrep, rgap, $urandom, 1, 8, -1, 1'b0);
        end

        // Reset in the middle of a gap returns everything to reset values.
        clear_q();
        cmd_valid = 1'b1;
        cmd_sw    = 9'h00C;
        cmd_rep   = 8'd3;
        cmd_gap   = 16'd20;
        cmd_wid   = 32'h55;
        step();
        cmd_valid = 1'b0;
        budget = 0;
        while (!pulse_start && budget < 50) begin
            step();
            budget++;
        end
        chk("rst_test_pulse_seen", pulse_start, 1);
        p = cyc;
        while (cyc < p + 2) step();
        pulse_done = 1'b1;
        step();
        pulse_done = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_sw", sw, SW_IDLE_V);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_idx", pulse_idx, 0);
        chk("midrst_wid_q", wid_q, 0);
        chk("midrst_bias_start", bias_start, 0);
        chk("midrst_seq_done", seq_done, 0);
        chk("midrst_aborted", aborted, 0);
        chk("midrst_err", err_timeout, 0);
        rst_n = 1'b1;
        clear_q();
        for (int i = 0; i < 30; i++) step();
        chk("midrst_no_strobes", q_bias.size() + q_pulse.size() + q_done.size(), 0);

`ifdef SEQ_WDOG_EN
        // Withheld pulse_done trips the watchdog after WDOG cycles in WAIT_DONE.
        cmd_valid = 1'b1;
        cmd_sw    = 9'h011;
        cmd_rep   = 8'd1;
        cmd_gap   = 16'd0;
        cmd_wid   = 32'h7;
        step();
        cmd_valid = 1'b0;
        budget = 0;
        while (!pulse_start && budget < 50) begin
            step();
            budget++;
        end
        chk("wdog_pulse_seen", pulse_start, 1);
        p = cyc;
        while (cyc < p + int'(WDOG) + 1) step();
        chk("wdog_aborted", aborted, 1);
        chk("wdog_err", err_timeout, 1);
        chk("wdog_busy", busy, 0);
        chk("wdog_sw", sw, SW_IDLE_V);
        step();
        chk("wdog_err_sticky", err_timeout, 1);
        chk("wdog_aborted_one_cycle", aborted, 0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("wdog_err_cleared", err_timeout, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
